// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared widths and constants for the EX/MEM pipeline register.
//   REG_W/ADDR_W/OP_W/STALL_W : default bus widths.
//   STALL_EX/STALL_MEM        : stall vector bit indices.
//   RST_ENABLE                : reset level (active low).
//   ZERO_WORD/EXE_NOP_OP      : reset/bubble values.
package ex_mem_pkg;
  localparam int REG_W   = 32;
  localparam int ADDR_W  = 5;
  localparam int OP_W    = 8;
  localparam int STALL_W = 6;

  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  localparam logic RST_ENABLE = 1'b0;

  localparam logic [REG_W-1:0] ZERO_WORD  = '0;
  localparam logic [OP_W-1:0]  EXE_NOP_OP = 8'h00;
endpackage

// File: rtl/ex_mem.sv
// ex_mem: EX -> MEM pipeline register of the five-stage core.
//   clk/rst      : rising-edge clock, async active-low reset
//   stall/flush  : global stall vector and exception flush from ctrl
//   ex_*         : execute-stage results, registered onto mem_*
//   hilo_i/cnt_i : madd/msub partial product and cycle count from ex,
//                  looped back on hilo_o/cnt_o while ex is stalled
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int REG_W   = ex_mem_pkg::REG_W,
  parameter int ADDR_W  = ex_mem_pkg::ADDR_W,
  parameter int OP_W    = ex_mem_pkg::OP_W,
  parameter int STALL_W = ex_mem_pkg::STALL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  ex_wd,
  input  logic               ex_wreg,
  input  logic [REG_W-1:0]   ex_wdata,
  input  logic [REG_W-1:0]   ex_hi,
  input  logic [REG_W-1:0]   ex_lo,
  input  logic               ex_whilo,
  input  logic [OP_W-1:0]    ex_aluop,
  input  logic [REG_W-1:0]   ex_mem_addr,
  input  logic [REG_W-1:0]   ex_reg2,
  input  logic [63:0]        hilo_i,
  input  logic [1:0]         cnt_i,
  output logic [ADDR_W-1:0]  mem_wd,
  output logic               mem_wreg,
  output logic [REG_W-1:0]   mem_wdata,
  output logic [REG_W-1:0]   mem_hi,
  output logic [REG_W-1:0]   mem_lo,
  output logic               mem_whilo,
  output logic [OP_W-1:0]    mem_aluop,
  output logic [REG_W-1:0]   mem_mem_addr,
  output logic [REG_W-1:0]   mem_reg2,
  output logic [63:0]        hilo_o,
  output logic [1:0]         cnt_o
);

  logic w_ex_stall, w_mem_stall;
  assign w_ex_stall  = stall[STALL_EX];
  assign w_mem_stall = stall[STALL_MEM];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      mem_wd       <= '0;
      mem_wreg     <= 1'b0;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= 1'b0;
      mem_aluop    <= OP_W'(EXE_NOP_OP);
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      hilo_o       <= '0;
      cnt_o        <= '0;
    end else if (flush) begin
      // Exception flush beats any stall, and also kills an in-flight madd.
      mem_wd       <= '0;
      mem_wreg     <= 1'b0;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= 1'b0;
      mem_aluop    <= OP_W'(EXE_NOP_OP);
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      hilo_o       <= '0;
      cnt_o        <= '0;
    end else if (w_ex_stall && !w_mem_stall) begin
      // Ex stalled while mem moves on: bubble into mem, and park the
      // multi-cycle partial product so ex can pick it up next cycle.
      mem_wd       <= '0;
      mem_wreg     <= 1'b0;
      mem_wdata    <= '0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_whilo    <= 1'b0;
      mem_aluop    <= OP_W'(EXE_NOP_OP);
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      hilo_o       <= hilo_i;
      cnt_o        <= cnt_i;
    end else if (!w_ex_stall) begin
      // Normal advance; the unreachable !ex && mem combination lands here too.
      mem_wd       <= ex_wd;
      mem_wreg     <= ex_wreg;
      mem_wdata    <= ex_wdata;
      mem_hi       <= ex_hi;
      mem_lo       <= ex_lo;
      mem_whilo    <= ex_whilo;
      mem_aluop    <= ex_aluop;
      mem_mem_addr <= ex_mem_addr;
      mem_reg2     <= ex_reg2;
      hilo_o       <= '0;
      cnt_o        <= '0;
    end
    // ex and mem both stalled: every register holds.
  end

endmodule

// File: tb/tb_ex_mem.sv
module tb_ex_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0, ex_hi = '0, ex_lo = '0, ex_mem_addr = '0, ex_reg2 = '0;
  logic        ex_whilo = 1'b0;
  logic [7:0]  ex_aluop = '0;
  logic [63:0] hilo_i = '0;
  logic [1:0]  cnt_i = '0;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int errs = 0;
  int chks = 0;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  // ctrl stalls contiguously: mem stalled while ex runs is illegal.
  always @(posedge clk)
    if (rst) assert (!(!stall[3] && stall[4])) else $error("illegal stall vector %b", stall);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic all_in(input logic [31:0] v);
    ex_wd = v[4:0]; ex_wreg = 1'b1; ex_wdata = v; ex_hi = ~v; ex_lo = v ^ 32'h0F0F_0F0F;
    ex_whilo = 1'b1; ex_aluop = v[7:0] | 8'h01; ex_mem_addr = v + 32'd4; ex_reg2 = ~v + 32'd1;
    hilo_i = {v, ~v}; cnt_i = 2'd2;
  endtask

  initial begin
    // power-on reset
    @(negedge clk);
    chk("por_wdata", 64'(mem_wdata), 64'h0);
    chk("por_aluop", 64'(mem_aluop), 64'h0);
    rst = 1'b1;

    // fill the pipe with nonzero data, then async reset mid-cycle
    all_in(32'hCAFE_1357);
    step();
    chk("pre_rst_wdata", 64'(mem_wdata), 64'hCAFE_1357);
    chk("pre_rst_addr", 64'(mem_mem_addr), 64'hCAFE_135B);
    #2 rst = 1'b0;
    #1;
    chk("async_wd", 64'(mem_wd), 64'h0);
    chk("async_wreg", 64'(mem_wreg), 64'h0);
    chk("async_wdata", 64'(mem_wdata), 64'h0);
    chk("async_hi", 64'(mem_hi), 64'h0);
    chk("async_lo", 64'(mem_lo), 64'h0);
    chk("async_whilo", 64'(mem_whilo), 64'h0);
    chk("async_aluop", 64'(mem_aluop), 64'h0);
    chk("async_reg2", 64'(mem_reg2), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    ex_wdata = 32'h1234_5678; stall = 6'b000000;
    step();
    chk("post_rst_wdata", 64'(mem_wdata), 64'h1234_5678);

    // normal advance
    ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_0000; stall = 6'b000000;
    step();
    chk("adv_wd", 64'(mem_wd), 64'd3);
    chk("adv_wreg", 64'(mem_wreg), 64'd1);
    chk("adv_wdata", 64'(mem_wdata), 64'hFFFF_0000);
    chk("adv_hilo", hilo_o, 64'h0);
    chk("adv_cnt", 64'(cnt_o), 64'h0);

    // bubble
    stall = 6'b001111; hilo_i = 64'hA5; cnt_i = 2'd1;
    step();
    chk("bub_wreg", 64'(mem_wreg), 64'h0);
    chk("bub_wdata", 64'(mem_wdata), 64'h0);
    chk("bub_aluop", 64'(mem_aluop), 64'h0);
    chk("bub_hilo", hilo_o, 64'hA5);
    chk("bub_cnt", 64'(cnt_o), 64'd1);

    // hold after bubble keeps the parked partial product
    stall = 6'b011111; hilo_i = 64'h77; cnt_i = 2'd3; ex_wdata = 32'h5555_AAAA;
    step();
    step();
    chk("hold_bub_hilo", hilo_o, 64'hA5);
    chk("hold_bub_cnt", 64'(cnt_o), 64'd1);
    chk("hold_bub_wdata", 64'(mem_wdata), 64'h0);

    // load DEADBEEF, then hold 3 cycles with changing inputs
    stall = 6'b000000; ex_wdata = 32'hDEAD_BEEF;
    step();
    chk("load_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      ex_wdata = 32'h1111_0000 + i; hilo_i = 64'hBEEF + i; cnt_i = 2'(i + 1);
      step();
      chk("hold_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      chk("hold_hilo", hilo_o, 64'h0);
      chk("hold_cnt", 64'(cnt_o), 64'h0);
    end

    // flush over stall
    flush = 1'b1; stall = 6'b011111; all_in(32'h9876_5432);
    step();
    chk("fl_wd", 64'(mem_wd), 64'h0);
    chk("fl_wdata", 64'(mem_wdata), 64'h0);
    chk("fl_aluop", 64'(mem_aluop), 64'h0);
    chk("fl_hilo", hilo_o, 64'h0);
    chk("fl_cnt", 64'(cnt_o), 64'h0);
    // flush also clears a parked madd: park, then flush during bubble stall
    flush = 1'b0; stall = 6'b001111;
    step();
    chk("park_hilo", hilo_o, {32'h9876_5432, ~32'h9876_5432});
    flush = 1'b1;
    step();
    chk("fl_park_hilo", hilo_o, 64'h0);
    flush = 1'b0;

    // madd sequence
    all_in(32'h0); ex_wreg = 1'b0; ex_whilo = 1'b0; cnt_i = 2'd0; ex_aluop = 8'h00;
    stall = 6'b001111; hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
    step();
    chk("madd1_hilo", hilo_o, 64'h1_0000_0002);
    chk("madd1_cnt", 64'(cnt_o), 64'd1);
    chk("madd1_whilo", 64'(mem_whilo), 64'h0);
    stall = 6'b000000; ex_hi = 32'h1; ex_lo = 32'h5; ex_whilo = 1'b1;
    hilo_i = 64'h0; cnt_i = 2'd2;
    step();
    chk("madd2_whilo", 64'(mem_whilo), 64'd1);
    chk("madd2_hi", 64'(mem_hi), 64'h1);
    chk("madd2_lo", 64'(mem_lo), 64'h5);
    chk("madd2_hilo", hilo_o, 64'h0);
    chk("madd2_cnt", 64'(cnt_o), 64'h0);

    // reset in the middle of a madd
    stall = 6'b001111; hilo_i = 64'h3_0000_0004; cnt_i = 2'd1;
    step();
    chk("madd_mid_cnt", 64'(cnt_o), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("madd_rst_cnt", 64'(cnt_o), 64'h0);
    chk("madd_rst_hilo", hilo_o, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim did not finish, limit %0d", 20000);
    $fatal(1, "timeout");
  end
endmodule
